mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles a read may wait in WAIT_RESP; range 2..65535.
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-high.
REQ-004 imem_req_valid/ready  in/out  1/1  instruction requester handshake.
REQ-005 imem_req_bits_addr/data/fcn/typ  in  32/32/1/3  instruction request payload (fcn 0=read, 1=write).
REQ-006 imem_resp_valid/bits_data  out  1/32  instruction response.
REQ-007 dmem_req_valid/ready, dmem_req_bits_addr/data/fcn/typ, dmem_resp_valid/bits_data: same as REQ-004..006 for the data requester.
REQ-008 mem_req_valid/ready  out/in  1/1  shared memory port handshake.
REQ-009 mem_req_bits_addr/data/fcn/typ  out  32/32/1/3  registered request payload.
REQ-010 mem_resp_valid/bits_data  in  1/32  shared memory response.
REQ-011 timeout_err  out  1  sticky read-timeout flag.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT_RESP; one transaction outstanding at a time.
REQ-013 IDLE: winner = the only valid requester; if both are valid, the requester not granted last (round-robin).
REQ-014 IDLE: the winner's req_ready is asserted combinationally; the loser's req_ready and both req_ready in other states are 0.
REQ-015 Accept (valid&&ready): latch payload and owner, update last_grant, go to ISSUE next cycle.
REQ-016 ISSUE: mem_req_valid=1 with the latched payload, held stable until mem_req_ready is seen.
REQ-017 ISSUE with mem_req_ready: fcn=1 (write) returns to IDLE with no response to the requester; fcn=0 goes to WAIT_RESP.
REQ-018 WAIT_RESP with mem_resp_valid: owner's resp_valid pulses for exactly 1 cycle with resp_bits_data=mem_resp_bits_data; next state IDLE.
REQ-019 Response routing: the non-owner's resp_valid is always 0; mem_resp_valid outside WAIT_RESP is ignored.
REQ-020 Minimum read latency: accept at cycle N, mem_req_valid at N+1, owner response in the cycle mem_resp_valid arrives (earliest N+2).
REQ-021 Back-to-back: IDLE may accept a new request in the cycle after a write completes or a response is delivered.
REQ-022 Timeout counter: 16-bit, cleared on entering WAIT_RESP, increments each WAIT_RESP cycle without a response.
REQ-023 Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no response, owner resp_valid pulses with data 32'h0, timeout_err sets, next state IDLE.
REQ-024 Simultaneous response and timeout in the same cycle: the response wins, data is forwarded, timeout_err is not set.
REQ-025 timeout_err is cleared only by reset.
REQ-026 Request payload inputs are sampled only at accept; changes afterwards have no effect.

Reset
REQ-027 Reset asserted at any time: state=IDLE, last_grant=imem (dmem wins the first tie), counter=0, timeout_err=0, payload registers=0.
REQ-028 During reset all valid/ready outputs are 0; a transaction in flight is abandoned and no response is delivered.
REQ-029 A mem_resp_valid arriving after reset deassertion for an abandoned read is ignored (falls under REQ-019).

Structure
REQ-030 Shared package holds: the FSM state enum, owner enum (IMEM, DMEM), the fcn encodings M_XRD=0 and M_XWR=1, and the typ width constant 3.
REQ-031 One sub-module, rr_arbiter2: two-input round-robin grant with a last_grant register; everything else is flat.

Verification
REQ-032 Only imem valid, read addr 0x100, memory ready immediately, response 0xDEADBEEF 1 cycle later -> imem_resp_valid 1 cycle with 0xDEADBEEF, dmem_resp_valid stays 0.
REQ-033 Both requesters valid continuously for 4 transactions after reset -> grant order dmem, imem, dmem, imem.
REQ-034 dmem write (fcn=1, addr 0x200, data 0x12345678), mem_req_ready low for 3 cycles -> payload stable 3 cycles, return to IDLE, no dmem_resp_valid.
REQ-035 imem read, mem_resp_valid never arrives, TIMEOUT_CYCLES=8 -> imem_resp_valid with 0x0 at the 8th WAIT_RESP cycle and timeout_err=1 until reset.
REQ-036 Reset asserted in WAIT_RESP, stray mem_resp_valid after release -> no resp_valid on either requester, state IDLE, timeout_err=0.
REQ-037 mem_resp_valid on the exact timeout cycle with data 0xA5A5A5A5 -> data forwarded, timeout_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int TYP_W = 3;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ISSUE     = 2'd1;
  localparam state_t ST_WAIT_RESP = 2'd2;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie, the input not granted last wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  owner_e last_grant_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      localparam owner_e SELF = (gi == 0) ? OWN_IMEM : OWN_DMEM;
      assign grant[gi] = req[gi] && (!req[1-gi] || (last_grant_reg != SELF));
    end
  endgenerate

  // Any grant is an accept, since the requester's valid is already in req.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= OWN_IMEM;
    end else if (|grant) begin
      last_grant_reg <= grant[1] ? OWN_DMEM : OWN_IMEM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction and data requesters onto one memory port, one
// transaction outstanding, with a read-response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imem_req_valid,
  output logic             imem_req_ready,
  input  logic [31:0]      imem_req_bits_addr,
  input  logic [31:0]      imem_req_bits_data,
  input  logic             imem_req_bits_fcn,
  input  logic [TYP_W-1:0] imem_req_bits_typ,
  output logic             imem_resp_valid,
  output logic [31:0]      imem_resp_bits_data,
  input  logic             dmem_req_valid,
  output logic             dmem_req_ready,
  input  logic [31:0]      dmem_req_bits_addr,
  input  logic [31:0]      dmem_req_bits_data,
  input  logic             dmem_req_bits_fcn,
  input  logic [TYP_W-1:0] dmem_req_bits_typ,
  output logic             dmem_resp_valid,
  output logic [31:0]      dmem_resp_bits_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_bits_addr,
  output logic [31:0]      mem_req_bits_data,
  output logic             mem_req_bits_fcn,
  output logic [TYP_W-1:0] mem_req_bits_typ,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_bits_data,
  output logic             timeout_err
);

  state_t           state_reg, state_next;
  owner_e           owner_reg;
  logic [31:0]      addr_reg, data_reg;
  logic             fcn_reg;
  logic [TYP_W-1:0] typ_reg;
  logic [15:0]      cnt_reg;
  logic             timeout_err_reg;

  logic [1:0]  arb_req, grant;
  logic        accept, in_wait, timeout_hit, resp_fire;
  logic [31:0] resp_data;

  // Gating with reset keeps both req_ready low while reset is held.
  assign arb_req = (state_reg == ST_IDLE && !reset) ? {dmem_req_valid, imem_req_valid} : 2'b00;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .grant (grant)
  );

  assign imem_req_ready = grant[0];
  assign dmem_req_ready = grant[1];
  assign accept         = |grant;

  assign in_wait     = (state_reg == ST_WAIT_RESP);
  assign timeout_hit = (cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign resp_fire   = in_wait && (mem_resp_valid || timeout_hit);
  // A real response beats a timeout landing in the same cycle.
  assign resp_data   = mem_resp_valid ? mem_resp_bits_data : 32'h0;

  assign imem_resp_valid     = resp_fire && (owner_reg == OWN_IMEM);
  assign dmem_resp_valid     = resp_fire && (owner_reg == OWN_DMEM);
  assign imem_resp_bits_data = resp_data;
  assign dmem_resp_bits_data = resp_data;

  assign mem_req_valid     = (state_reg == ST_ISSUE);
  assign mem_req_bits_addr = addr_reg;
  assign mem_req_bits_data = data_reg;
  assign mem_req_bits_fcn  = fcn_reg;
  assign mem_req_bits_typ  = typ_reg;
  assign timeout_err       = timeout_err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (accept) state_next = ST_ISSUE;
      ST_ISSUE:     if (mem_req_ready) state_next = (fcn_reg == M_XWR) ? ST_IDLE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_fire) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= OWN_IMEM;
      addr_reg        <= '0;
      data_reg        <= '0;
      fcn_reg         <= M_XRD;
      typ_reg         <= '0;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        owner_reg <= grant[1] ? OWN_DMEM : OWN_IMEM;
        addr_reg  <= grant[1] ? dmem_req_bits_addr : imem_req_bits_addr;
        data_reg  <= grant[1] ? dmem_req_bits_data : imem_req_bits_data;
        fcn_reg   <= grant[1] ? dmem_req_bits_fcn  : imem_req_bits_fcn;
        typ_reg   <= grant[1] ? dmem_req_bits_typ  : imem_req_bits_typ;
      end
      if (state_next == ST_WAIT_RESP && !in_wait) begin
        cnt_reg <= '0;
      end else if (in_wait && !resp_fire) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
      if (in_wait && timeout_hit && !mem_resp_valid) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written
// reset and round-robin sequences, responses checked through a scoreboard.
module tb_mem_port_arbiter;

  localparam int T = 8;

  logic        clock, reset;
  logic        imem_req_valid, imem_req_ready, imem_req_bits_fcn, imem_resp_valid;
  logic [31:0] imem_req_bits_addr, imem_req_bits_data, imem_resp_bits_data;
  logic [2:0]  imem_req_bits_typ;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_bits_fcn, dmem_resp_valid;
  logic [31:0] dmem_req_bits_addr, dmem_req_bits_data, dmem_resp_bits_data;
  logic [2:0]  dmem_req_bits_typ;
  logic        mem_req_valid, mem_req_ready, mem_req_bits_fcn, mem_resp_valid;
  logic [31:0] mem_req_bits_addr, mem_req_bits_data, mem_resp_bits_data;
  logic [2:0]  mem_req_bits_typ;
  logic        timeout_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock               (clock),
    .reset               (reset),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_bits_addr  (imem_req_bits_addr),
    .imem_req_bits_data  (imem_req_bits_data),
    .imem_req_bits_fcn   (imem_req_bits_fcn),
    .imem_req_bits_typ   (imem_req_bits_typ),
    .imem_resp_valid     (imem_resp_valid),
    .imem_resp_bits_data (imem_resp_bits_data),
    .dmem_req_valid      (dmem_req_valid),
    .dmem_req_ready      (dmem_req_ready),
    .dmem_req_bits_addr  (dmem_req_bits_addr),
    .dmem_req_bits_data  (dmem_req_bits_data),
    .dmem_req_bits_fcn   (dmem_req_bits_fcn),
    .dmem_req_bits_typ   (dmem_req_bits_typ),
    .dmem_resp_valid     (dmem_resp_valid),
    .dmem_resp_bits_data (dmem_resp_bits_data),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_bits_addr   (mem_req_bits_addr),
    .mem_req_bits_data   (mem_req_bits_data),
    .mem_req_bits_fcn    (mem_req_bits_fcn),
    .mem_req_bits_typ    (mem_req_bits_typ),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_bits_data  (mem_resp_bits_data),
    .timeout_err         (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        who;
    logic        fcn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    int          rd;
    int          resp_delay;
    logic [31:0] resp_data;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        who;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every response must match the oldest pending read.
  always @(negedge clock) begin
    if (imem_resp_valid || dmem_resp_valid) begin
      chk("resp_onehot", 32'(imem_resp_valid && dmem_resp_valid), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_resp: got imem=%0b dmem=%0b, required none", imem_resp_valid, dmem_resp_valid);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("resp_owner", 32'(dmem_resp_valid), 32'(e.who));
        chk("resp_data", dmem_resp_valid ? dmem_resp_bits_data : imem_resp_bits_data, e.data);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_req(input logic who, input logic fcn, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] typ);
    if (who) begin
      dmem_req_valid = 1'b1; dmem_req_bits_fcn = fcn; dmem_req_bits_addr = addr;
      dmem_req_bits_data = data; dmem_req_bits_typ = typ;
    end else begin
      imem_req_valid = 1'b1; imem_req_bits_fcn = fcn; imem_req_bits_addr = addr;
      imem_req_bits_data = data; imem_req_bits_typ = typ;
    end
  endtask

  // Called at a negedge; returns how many extra cycles it waited for a grant.
  task automatic wait_accept(output logic who, output int waited);
    waited = 0;
    who = 1'b0;
    while (!(imem_req_ready || dmem_req_ready) && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) begin
      failed++;
      $display("FAIL accept_timeout: got no req_ready in 20 cycles, required a grant");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "accept wait expired");
    end
    chk("ready_onehot", 32'(imem_req_ready && dmem_req_ready), 32'd0);
    who = dmem_req_ready;
  endtask

  // Called at the negedge of the accept cycle; plays the memory side.
  task automatic serve(input logic fcn, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] typ, input int rd, input int resp_delay,
                       input logic [31:0] resp_data, input bit keep);
    int last;
    for (int i = 0; i <= rd; i++) begin
      @(posedge clock); #1;
      if (i == 0 && !keep) begin
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        imem_req_bits_addr = $urandom; imem_req_bits_data = $urandom;
        dmem_req_bits_addr = $urandom; dmem_req_bits_data = $urandom;
        imem_req_bits_fcn = 1'($urandom); dmem_req_bits_fcn = 1'($urandom);
        imem_req_bits_typ = 3'($urandom); dmem_req_bits_typ = 3'($urandom);
      end
      mem_req_ready = (i == rd);
      @(negedge clock);
      chk("issue_valid", 32'(mem_req_valid), 32'd1);
      chk("issue_addr", mem_req_bits_addr, addr);
      chk("issue_data", mem_req_bits_data, data);
      chk("issue_fcn_typ", {28'd0, mem_req_bits_fcn, mem_req_bits_typ}, {28'd0, fcn, typ});
    end
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    if (fcn == 1'b0) begin
      last = (resp_delay < T - 1) ? resp_delay : T - 1;
      for (int k = 0; k <= last; k++) begin
        mem_resp_valid     = (k == resp_delay);
        mem_resp_bits_data = (k == resp_delay) ? resp_data : $urandom;
        @(posedge clock); #1;
      end
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_imem_ready"}, 32'(imem_req_ready), 32'd0);
    chk({tag, "_dmem_ready"}, 32'(dmem_req_ready), 32'd0);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_imem_resp"}, 32'(imem_resp_valid), 32'd0);
    chk({tag, "_dmem_resp"}, 32'(dmem_resp_valid), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_addr"}, mem_req_bits_addr, 32'd0);
    chk({tag, "_data"}, mem_req_bits_data, 32'd0);
  endtask

  initial begin
    logic who;
    int   waited;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 3'd2, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h204, 32'h0, 3'd2, 2, 3, 32'h0BADF00D, 32'h0BADF00D, 7, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'h12345678, 3'd2, 3, 0, 32'h0, 32'h0, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h40, 32'hCAFEBABE, 3'd1, 0, 0, 32'h0, 32'h0, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h300, 32'h0, 3'd2, 1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 10, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h104, 32'h0, 3'd0, 0, 5, 32'h600DCAFE, 32'h600DCAFE, 7, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h108, 32'h0, 3'd2, 0, 100, 32'h77777777, 32'h0, 9, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h10C, 32'h0, 3'd2, 0, 1, 32'h11112222, 32'h11112222, 3, 1'b1};

    reset = 1'b1;
    imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
    imem_req_bits_addr = 32'h0; imem_req_bits_data = 32'h0; imem_req_bits_fcn = 1'b0; imem_req_bits_typ = 3'd0;
    dmem_req_bits_addr = 32'h0; dmem_req_bits_data = 32'h0; dmem_req_bits_fcn = 1'b0; dmem_req_bits_typ = 3'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_bits_data = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      drive_req(v.who, v.fcn, v.addr, v.data, v.typ);
      $display("[TB] vec %0d who=%0d fcn=%0d addr=%h", i, v.who, v.fcn, v.addr);
      @(negedge clock);
      chk("idle_mem_valid", 32'(mem_req_valid), 32'd0);
      if (i > 0) chk("timeout_err", 32'(timeout_err), 32'(vecs[i-1].exp_err));
      wait_accept(who, waited);
      chk("b2b_accept", waited, 0);
      chk("grant_owner", 32'(who), 32'(v.who));
      if (v.fcn == 1'b0) sb.push_back('{v.who, v.exp_data, cyc + v.exp_lat});
      serve(v.fcn, v.addr, v.data, v.typ, v.rd, v.resp_delay, v.resp_data, 1'b0);
    end
    @(negedge clock);
    chk("timeout_err_sticky", 32'(timeout_err), 32'(vecs[7].exp_err));

    // Reset while a read is outstanding, then a stray response afterwards.
    @(posedge clock); #1;
    $display("[TB] reset during WAIT_RESP");
    drive_req(1'b0, 1'b0, 32'h500, 32'h0, 3'd2);
    @(negedge clock);
    wait_accept(who, waited);
    @(posedge clock); #1;
    imem_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    reset = 1'b1;
    imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
    @(negedge clock);
    check_reset("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_bits_data = 32'hFFFF0000;
    @(posedge clock); #1;
    mem_resp_valid = 1'b0;
    @(negedge clock);
    chk("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("stray_timeout_err", 32'(timeout_err), 32'd0);

    // Both requesters held valid: dmem wins the first tie after reset.
    @(posedge clock); #1;
    drive_req(1'b0, 1'b0, 32'h1000, 32'h0, 3'd2);
    drive_req(1'b1, 1'b0, 32'h2000, 32'h0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      wait_accept(who, waited);
      $display("[TB] rr %0d granted %s", i, who ? "dmem" : "imem");
      chk("rr_order", 32'(who), 32'((i % 2) == 0));
      sb.push_back('{who, 32'hC0DE0000 + 32'(i), cyc + 2});
      serve(1'b0, who ? 32'h2000 : 32'h1000, 32'h0, 3'd2, 0, 0, 32'hC0DE0000 + 32'(i), 1'b1);
    end
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, required completion");
    $fatal(1, "watchdog");
  end

endmodule
